// File: rtl/fpu_normalize_round.sv
// fpu_normalize_round
// Three-stage normalise-and-round unit sitting between the mantissa datapath
// and result packing. Finds the leading one of a wide unnormalised magnitude,
// aligns it, handles gradual underflow, rounds in one of four modes and packs
// an IEEE-style fraction/exponent with {ovf, uf, inexact, zero} flags.
//
// Pipeline: S1 leading-one detect + input capture, S2 alignment and
// guard/sticky formation, S3 rounding, exceptions and output registers.
// All stages advance together on en = !o_valid | o_ready; bubbles are kept.

module fpu_normalize_round #(
    parameter int BW_IN       = 48,
    parameter int BW_FRAC     = 23,
    parameter int BW_EXPN     = 10,
    parameter int SET_BW_EXPN = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [BW_IN-1:0]       i_frac,
    input  logic [BW_EXPN-1:0]     i_expn,
    input  logic                   i_sign,
    input  logic [1:0]             i_rnd,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [BW_FRAC-1:0]     o_frac,
    output logic [SET_BW_EXPN-1:0] o_expn,
    output logic                   o_sign,
    output logic [3:0]             o_flags
);

    // Internal exponent width: two guard bits so e = expn - lzc never wraps.
    localparam int EW        = BW_EXPN + 2;
    localparam int LZW       = $clog2(BW_IN + 1);
    localparam int MAX_EXPN  = 2**SET_BW_EXPN - 1;
    // Right shifts beyond SAT_SH push the hidden bit past the guard position,
    // so everything collapses into sticky.
    localparam int SAT_SH    = BW_FRAC + 2;
    localparam int PADW      = BW_FRAC + 3;
    localparam int SHW       = $clog2(PADW);
    localparam int XW        = BW_IN + PADW;
    localparam int SIGW      = BW_FRAC + 1;
    localparam int LOWW      = XW - SIGW - 1;

    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_SAT  = EW'(SAT_SH);
    localparam logic signed [EW-1:0] E_MAX  = EW'(MAX_EXPN);

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RUP = 2'd2,
        RND_RDN = 2'd3
    } rnd_t;

    logic w_en;

    // Stage 1 registers
    logic                       r1_valid;
    logic [BW_IN-1:0]           r1_frac;
    logic signed [BW_EXPN-1:0]  r1_expn;
    logic                       r1_sign;
    rnd_t                       r1_rnd;
    logic [LZW-1:0]             r1_lzc;
    logic                       r1_zero;

    // Stage 2 registers
    logic                       r2_valid;
    logic [SIGW-1:0]            r2_sig;
    logic                       r2_guard;
    logic                       r2_sticky;
    logic signed [EW-1:0]       r2_exp;
    logic                       r2_sign;
    rnd_t                       r2_rnd;
    logic                       r2_zero;

    // Stage 1 combinational
    logic [LZW-1:0]             w_lzc;
    logic                       w_in_zero;

    // Stage 2 combinational
    logic [BW_IN-1:0]           w_norm;
    logic signed [EW-1:0]       w_e;
    logic signed [EW-1:0]       w_sh_full;
    logic [SHW-1:0]             w_sh;
    logic                       w_sat;
    logic [XW-1:0]              w_ext;
    logic [SIGW-1:0]            w_sig;
    logic                       w_guard;
    logic                       w_sticky;
    logic signed [EW-1:0]       w_exp_pre;

    // Stage 3 combinational
    logic                       w_inc;
    logic [SIGW:0]              w_sum;
    logic signed [EW-1:0]       w_exp_fin;
    logic                       w_inexact;
    logic                       w_uf;
    logic                       w_ovf;
    logic                       w_to_inf;
    logic [BW_FRAC-1:0]         w_o_frac;
    logic [SET_BW_EXPN-1:0]     w_o_expn;
    logic [3:0]                 w_o_flags;

    assign w_en    = !o_valid || o_ready;
    assign i_ready = w_en;

    // Leading-one detect: highest set bit wins, reported as a left-shift count.
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < BW_IN; i++) begin
            if (i_frac[i]) begin
                w_lzc = LZW'(BW_IN - 1 - i);
            end
        end
        w_in_zero = (i_frac == '0);
    end

    // Stage 1 register: capture inputs together with the shift count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_frac  <= '0;
            r1_expn  <= '0;
            r1_sign  <= 1'b0;
            r1_rnd   <= RND_RNE;
            r1_lzc   <= '0;
            r1_zero  <= 1'b0;
        end else if (w_en) begin
            r1_valid <= i_valid;
            r1_frac  <= i_frac;
            r1_expn  <= i_expn;
            r1_sign  <= i_sign;
            r1_rnd   <= rnd_t'(i_rnd);
            r1_lzc   <= w_lzc;
            r1_zero  <= w_in_zero;
        end
    end

    // Align the leading one to the top, then denormalise if e <= 0 and
    // split into significand, guard and sticky.
    always_comb begin
        w_norm    = r1_frac << r1_lzc;
        w_e       = EW'(r1_expn) - $signed(EW'(r1_lzc));
        w_sh_full = E_ONE - w_e;
        w_sh      = '0;
        w_sat     = 1'b0;
        if (w_e < E_ONE) begin
            if (w_sh_full > E_SAT) begin
                w_sat = 1'b1;
            end else begin
                w_sh = w_sh_full[SHW-1:0];
            end
        end
        w_ext = {w_norm, {PADW{1'b0}}} >> w_sh;
        if (w_sat) begin
            w_sig    = '0;
            w_guard  = 1'b0;
            w_sticky = |w_norm;
        end else begin
            w_sig    = w_ext[XW-1 -: SIGW];
            w_guard  = w_ext[LOWW];
            w_sticky = |w_ext[LOWW-1:0];
        end
        w_exp_pre = (w_e < E_ONE) ? E_ZERO : w_e;
    end

    // Stage 2 register: aligned significand and pre-round exponent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid  <= 1'b0;
            r2_sig    <= '0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
            r2_exp    <= '0;
            r2_sign   <= 1'b0;
            r2_rnd    <= RND_RNE;
            r2_zero   <= 1'b0;
        end else if (w_en) begin
            r2_valid  <= r1_valid;
            r2_sig    <= w_sig;
            r2_guard  <= w_guard;
            r2_sticky <= w_sticky;
            r2_exp    <= w_exp_pre;
            r2_sign   <= r1_sign;
            r2_rnd    <= r1_rnd;
            r2_zero   <= r1_zero;
        end
    end

    // Round, propagate carries into the exponent and resolve exceptions.
    always_comb begin
        w_inc = 1'b0;
        case (r2_rnd)
            RND_RNE: w_inc = r2_guard && (r2_sticky || r2_sig[0]);
            RND_RTZ: w_inc = 1'b0;
            RND_RUP: w_inc = !r2_sign && (r2_guard || r2_sticky);
            RND_RDN: w_inc = r2_sign && (r2_guard || r2_sticky);
            default: w_inc = 1'b0;
        endcase

        w_sum = {1'b0, r2_sig} + (SIGW+1)'(w_inc);

        // A subnormal has no hidden bit, so reaching bit BW_FRAC means it
        // rounded up into the smallest normal. A normal carries out of the top.
        if (r2_exp == E_ZERO) begin
            w_exp_fin = w_sum[BW_FRAC] ? E_ONE : E_ZERO;
        end else begin
            w_exp_fin = r2_exp + (w_sum[SIGW] ? E_ONE : E_ZERO);
        end

        w_inexact = r2_guard || r2_sticky;
        w_uf      = w_inexact && (r2_exp == E_ZERO);
        w_ovf     = (w_exp_fin >= E_MAX);
        w_to_inf  = (r2_rnd == RND_RNE)
                 || ((r2_rnd == RND_RUP) && !r2_sign)
                 || ((r2_rnd == RND_RDN) && r2_sign);

        // On carry-out the low bits of w_sum are already zero.
        w_o_frac  = w_sum[BW_FRAC-1:0];
        w_o_expn  = w_exp_fin[SET_BW_EXPN-1:0];
        w_o_flags = {1'b0, w_uf, w_inexact, 1'b0};

        if (r2_zero) begin
            w_o_frac  = '0;
            w_o_expn  = '0;
            w_o_flags = 4'b0001;
        end else if (w_ovf) begin
            if (w_to_inf) begin
                w_o_frac = '0;
                w_o_expn = SET_BW_EXPN'(MAX_EXPN);
            end else begin
                w_o_frac = '1;
                w_o_expn = SET_BW_EXPN'(MAX_EXPN - 1);
            end
            w_o_flags = 4'b1010;
        end else if ((w_exp_fin == E_ZERO) && (w_sum[BW_FRAC-1:0] == '0)) begin
            w_o_flags[0] = 1'b1;
        end
    end

    // Stage 3 register: packed outputs, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_frac  <= '0;
            o_expn  <= '0;
            o_sign  <= 1'b0;
            o_flags <= '0;
        end else if (w_en) begin
            o_valid <= r2_valid;
            o_frac  <= w_o_frac;
            o_expn  <= w_o_expn;
            o_sign  <= r2_sign;
            o_flags <= w_o_flags;
        end
    end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Bench for fpu_normalize_round: directed vector table with hand-computed
// results, plus stall/backpressure and mid-stream reset sequences.

module tb_fpu_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [47:0] i_frac;
    logic [9:0]  i_expn;
    logic        i_sign;
    logic [1:0]  i_rnd;
    logic        o_valid;
    logic        o_ready;
    logic [22:0] o_frac;
    logic [7:0]  o_expn;
    logic        o_sign;
    logic [3:0]  o_flags;

    int n_err = 0;
    int n_chk = 0;

    fpu_normalize_round #(
        .BW_IN(48), .BW_FRAC(23), .BW_EXPN(10), .SET_BW_EXPN(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_frac(i_frac), .i_expn(i_expn), .i_sign(i_sign), .i_rnd(i_rnd),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_frac(o_frac), .o_expn(o_expn), .o_sign(o_sign), .o_flags(o_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] frac;
        logic [9:0]  expn;
        logic        sign;
        logic [1:0]  rnd;
        logic [22:0] efrac;
        logic [7:0]  eexpn;
        logic        esign;
        logic [3:0]  eflags;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic chk(input string nm, input int idx, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        i_frac  = vecs[i].frac;
        i_expn  = vecs[i].expn;
        i_sign  = vecs[i].sign;
        i_rnd   = vecs[i].rnd;
        i_valid = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", i, 48'(lat), 48'd3);
        chk("frac",    i, 48'(o_frac),  48'(vecs[i].efrac));
        chk("expn",    i, 48'(o_expn),  48'(vecs[i].eexpn));
        chk("sign",    i, 48'(o_sign),  48'(vecs[i].esign));
        chk("flags",   i, 48'(o_flags), 48'(vecs[i].eflags));
    endtask

    initial begin
        int k, ridx, nstall, seen;
        logic [47:0] sfrac;

        // rnd: 0 RNE, 1 RTZ, 2 RUP, 3 RDN; flags {ovf, uf, inexact, zero}
        vecs[0]  = '{48'h400000000000, 10'd127,  1'b0, 2'd0, 23'h000000, 8'd126, 1'b0, 4'b0000};
        vecs[1]  = '{48'h800000800000, 10'd127,  1'b0, 2'd0, 23'h000000, 8'd127, 1'b0, 4'b0010};
        vecs[2]  = '{48'h800001800000, 10'd127,  1'b0, 2'd0, 23'h000002, 8'd127, 1'b0, 4'b0010};
        vecs[3]  = '{48'hFFFFFFFFFFFF, 10'd254,  1'b0, 2'd0, 23'h000000, 8'd255, 1'b0, 4'b1010};
        vecs[4]  = '{48'hFFFFFFFFFFFF, 10'd254,  1'b0, 2'd1, 23'h7FFFFF, 8'd254, 1'b0, 4'b0010};
        vecs[5]  = '{48'h800000000000, 10'h3FE,  1'b0, 2'd0, 23'h100000, 8'd0,   1'b0, 4'b0000};
        vecs[6]  = '{48'h800000000001, 10'h3FE,  1'b0, 2'd2, 23'h100001, 8'd0,   1'b0, 4'b0110};
        vecs[7]  = '{48'h000000000000, 10'd5,    1'b1, 2'd0, 23'h000000, 8'd0,   1'b1, 4'b0001};
        vecs[8]  = '{48'h800000000000, 10'd300,  1'b0, 2'd1, 23'h7FFFFF, 8'd254, 1'b0, 4'b1010};
        vecs[9]  = '{48'h800000000000, 10'd300,  1'b1, 2'd2, 23'h7FFFFF, 8'd254, 1'b1, 4'b1010};
        vecs[10] = '{48'h800000000000, 10'd300,  1'b1, 2'd3, 23'h000000, 8'd255, 1'b1, 4'b1010};
        vecs[11] = '{48'hFFFFFFFFFFFF, 10'd254,  1'b0, 2'd2, 23'h000000, 8'd255, 1'b0, 4'b1010};
        vecs[12] = '{48'h800000000000, 10'h3D8,  1'b0, 2'd1, 23'h000000, 8'd0,   1'b0, 4'b0111};
        vecs[13] = '{48'h800000000000, 10'h3D8,  1'b0, 2'd2, 23'h000001, 8'd0,   1'b0, 4'b0110};
        vecs[14] = '{48'hFFFFFF000000, 10'd0,    1'b0, 2'd0, 23'h000000, 8'd1,   1'b0, 4'b0110};
        vecs[15] = '{48'h800000000001, 10'd100,  1'b1, 2'd3, 23'h000001, 8'd100, 1'b1, 4'b0010};
        vecs[16] = '{48'h000000000001, 10'd127,  1'b0, 2'd0, 23'h000000, 8'd80,  1'b0, 4'b0000};
        vecs[17] = '{48'h00000000003F, 10'd100,  1'b0, 2'd0, 23'h7C0000, 8'd58,  1'b0, 4'b0000};
        vecs[18] = '{48'h800000C00000, 10'd127,  1'b0, 2'd0, 23'h000001, 8'd127, 1'b0, 4'b0010};
        vecs[19] = '{48'h800000C00000, 10'd127,  1'b1, 2'd2, 23'h000000, 8'd127, 1'b1, 4'b0010};
        vecs[20] = '{48'h800000000000, 10'h3E9,  1'b0, 2'd0, 23'h000000, 8'd0,   1'b0, 4'b0111};

        rst = 1'b1; i_valid = 1'b0; i_frac = '0; i_expn = '0; i_sign = 1'b0;
        i_rnd = 2'd0; o_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_o_valid", 0, 48'(o_valid), 48'd0);
        chk("rst_o_frac",  0, 48'(o_frac),  48'd0);
        chk("rst_o_expn",  0, 48'(o_expn),  48'd0);
        chk("rst_o_flags", 0, 48'(o_flags), 48'd0);
        chk("rst_o_sign",  0, 48'(o_sign),  48'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_i_ready", 0, 48'(i_ready), 48'd1);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Back-to-back stream with a 5-cycle downstream stall.
        k = 0; ridx = 0; nstall = 0;
        for (int cyc = 0; cyc < 60 && ridx < 6; cyc++) begin
            @(negedge clk);
            o_ready = !(cyc >= 4 && cyc <= 8);
            if (k < 6) begin
                sfrac   = 48'h800000000000 | (48'(3*k + 1) << 24);
                i_frac  = sfrac;
                i_expn  = 10'(10 + k);
                i_sign  = 1'b0;
                i_rnd   = 2'd1;
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (!o_ready) begin
                nstall++;
                chk("stall_o_valid", ridx, 48'(o_valid), 48'd1);
                chk("stall_i_ready", ridx, 48'(i_ready), 48'd0);
                chk("stall_frac",    ridx, 48'(o_frac),  48'(3*ridx + 1));
                chk("stall_expn",    ridx, 48'(o_expn),  48'(10 + ridx));
            end
            if (o_valid && o_ready) begin
                chk("stream_frac",  ridx, 48'(o_frac),  48'(3*ridx + 1));
                chk("stream_expn",  ridx, 48'(o_expn),  48'(10 + ridx));
                chk("stream_flags", ridx, 48'(o_flags), 48'd0);
                ridx++;
            end
            if (i_valid && i_ready) k++;
        end
        chk("stream_delivered", 0, 48'(ridx), 48'd6);
        chk("stream_accepted",  0, 48'(k), 48'd6);
        chk("stream_stall_cycles", 0, 48'(nstall), 48'd5);
        @(negedge clk);
        i_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        chk("stream_no_dup", 0, 48'(seen), 48'd0);

        // Reset with two beats in flight: they must be dropped.
        o_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            i_frac  = 48'h400000000000;
            i_expn  = 10'd50;
            i_sign  = 1'b1;
            i_rnd   = 2'd0;
            i_valid = 1'b1;
        end
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_o_valid", 0, 48'(o_valid), 48'd0);
        chk("midrst_o_sign",  0, 48'(o_sign),  48'd0);
        chk("midrst_o_expn",  0, 48'(o_expn),  48'd0);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        chk("midrst_dropped", 0, 48'(seen), 48'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
